scaler_frame_ctl: RTL
=====================

Name: scaler_frame_ctl

Overview:
- Frame-level sequencer for the separable bilinear scaler: one horizontal and one vertical instance of the Bresenham-style scaler core.
- Latches frame geometry and re-initialises both cores at the frame start and at each line start. Steps the vertical core once per line slot and runs the horizontal core across each output line.
- Handshakes line availability with the upstream line buffer and the downstream writer.
- Sits between the frame-sync logic and the two core instances inside the stream scaler.

Parameters:
C_W_WIDTH, 12, bit width of horizontal pixel counts (src/dst width)
C_H_WIDTH, 12, bit width of vertical line counts (src/dst height)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame-start pulse; honoured only in IDLE
abort  in  1  pulse; terminates the frame in progress
cfg_s_width  in  C_W_WIDTH  source pixels per line
cfg_m_width  in  C_W_WIDTH  output pixels per line
cfg_s_height  in  C_H_WIDTH  source lines
cfg_m_height  in  C_H_WIDTH  output lines
s_line_avail  in  1  upstream has a complete source line buffered
m_line_ready  in  1  downstream can accept pixels this cycle
h_s_nbr / h_m_nbr  out  C_W_WIDTH  shadow widths to the horizontal core
v_s_nbr / v_m_nbr  out  C_H_WIDTH  shadow heights to the vertical core
h_core_resetn  out  1  active-low sync init of the horizontal core
v_core_resetn  out  1  active-low sync init of the vertical core
h_enable  out  1  horizontal core enable
v_enable  out  1  vertical core enable
h_a_last  in  1  horizontal core: final step of line
v_a_last  in  1  vertical core: final step of frame
v_d_valid  in  1  vertical core: current step emits an output line
v_s_advance  in  1  vertical core: current step consumes a source line
s_line_pop  out  1  1-cycle pulse: release oldest source line
m_line_done  out  1  1-cycle pulse: output line complete
out_line  out  C_H_WIDTH  index of the output line being produced
busy  out  1  high in every state except IDLE
frame_done  out  1  1-cycle pulse at normal frame end
cfg_err  out  1  1-cycle pulse: start rejected

Behaviour:
- Reset values: h_core_resetn = v_core_resetn = 0 (cores held in init); all other outputs 0; state IDLE; shadow registers 0.
- Reset is async assert and sync release. Mid-frame reset drops to IDLE immediately; no pulses are emitted.

States:
- IDLE: cores held in init.
  - On start with any cfg_* equal to 0: pulse cfg_err next cycle, stay in IDLE.
  - On start otherwise: latch all cfg_* into shadows, then go to CLR.
  - cfg_* changes outside IDLE have no effect.
- CLR: exactly 2 cycles with both core_resetn = 0 and shadows stable; out_line = 0; then VSTEP.
- VSTEP: v_enable = 1 for exactly 1 cycle; then VEVAL.
- VEVAL: 1 cycle; samples v_d_valid, v_s_advance and v_a_last, which now reflect the new step.
  - If v_d_valid: go to HWAIT.
  - Else (source-only step): pulse s_line_pop; go to DONE if v_a_last, else VSTEP.
- HWAIT: wait for s_line_avail = 1, then HRUN.
- HRUN: h_enable = m_line_ready, which is combinational, so no pixel is issued without downstream acceptance.
  - h_a_last sampled while h_enable = 1 ends the line and goes to LEND.
- LEND: 1 cycle.
  - Pulse m_line_done.
  - Pulse s_line_pop if the VEVAL-sampled v_s_advance = 1.
  - h_core_resetn = 0 for this cycle.
  - out_line += 1, saturating at cfg_m_height − 1.
  - Next state: DONE if the sampled v_a_last = 1, else VSTEP.
- DONE: pulse frame_done; both core_resetn = 0; return to IDLE.

Boundary conditions:
- abort in any non-IDLE state: next cycle goes to IDLE, both core_resetn = 0, no frame_done.
  - If abort coincides with h_a_last in HRUN, abort wins: no m_line_done.
- start while busy is ignored, and no cfg_err is raised.
- start and abort in the same cycle in IDLE: start wins.
- m_line_ready low in HRUN stalls the cores in place; state is held indefinitely.
- 1:1 geometry (s = m) yields exactly cfg_m_height m_line_done pulses and cfg_s_height s_line_pop pulses.
- Every frame satisfies: count of m_line_done = cfg_m_height; count of s_line_pop = cfg_s_height.

Test Plan:
- Geometry 4×4 → 4×4, s_line_avail and m_line_ready tied high, start → 4 m_line_done, 4 s_line_pop, h_enable high for 4 cycles per line, out_line 0..3, one frame_done.
- Vertical 4 → 2 lines, widths 8 → 8 → 2 m_line_done, 4 s_line_pop (2 from VEVAL source-only steps), frame_done after the last LEND.
- Vertical upscale 2 → 5, width 3 → 6 → 5 m_line_done, 2 s_line_pop, 6 h_enable cycles per line; toggling m_line_ready 1-0-1 stretches HRUN with no extra h_enable.
- cfg_m_height = 0 with start → cfg_err pulse, busy stays 0; then a valid start latches the new cfg, and a cfg change mid-frame leaves h_m_nbr/v_m_nbr unchanged.
- abort asserted in HRUN on the 2nd output line → IDLE next cycle, core_resetn low, no frame_done, no m_line_done; a subsequent start runs a full frame correctly.
- reset asserted mid-HRUN asynchronously (between clk edges) → all outputs 0 and core_resetn low immediately, state IDLE after release.

Source files
------------

// File: rtl/scaler_frame_ctl.sv
// Frame/line sequencer for the separable bilinear scaler: drives one horizontal
// and one vertical scaler core and handshakes lines with the buffer and writer.
module scaler_frame_ctl #(
    parameter int C_W_WIDTH = 12,
    parameter int C_H_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [C_W_WIDTH-1:0] cfg_s_width,
    input  logic [C_W_WIDTH-1:0] cfg_m_width,
    input  logic [C_H_WIDTH-1:0] cfg_s_height,
    input  logic [C_H_WIDTH-1:0] cfg_m_height,
    input  logic                 s_line_avail,
    input  logic                 m_line_ready,
    output logic [C_W_WIDTH-1:0] h_s_nbr,
    output logic [C_W_WIDTH-1:0] h_m_nbr,
    output logic [C_H_WIDTH-1:0] v_s_nbr,
    output logic [C_H_WIDTH-1:0] v_m_nbr,
    output logic                 h_core_resetn,
    output logic                 v_core_resetn,
    output logic                 h_enable,
    output logic                 v_enable,
    input  logic                 h_a_last,
    input  logic                 v_a_last,
    input  logic                 v_d_valid,
    input  logic                 v_s_advance,
    output logic                 s_line_pop,
    output logic                 m_line_done,
    output logic [C_H_WIDTH-1:0] out_line,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_VSTEP, S_VEVAL, S_HWAIT, S_HRUN, S_LEND, S_DONE
    } state_t;

    localparam logic [C_H_WIDTH-1:0] H_ONE = C_H_WIDTH'(1);

    state_t               state_reg, state_next;
    logic                 clr_cnt_reg;
    logic                 s_adv_reg;
    logic                 a_last_reg;
    logic                 cfg_err_reg;
    logic [C_H_WIDTH-1:0] out_line_reg;
    logic [C_W_WIDTH-1:0] h_s_nbr_reg, h_m_nbr_reg;
    logic [C_H_WIDTH-1:0] v_s_nbr_reg, v_m_nbr_reg;
    logic                 cfg_bad;
    logic                 start_ok;

    assign cfg_bad  = (cfg_s_width == '0) || (cfg_m_width == '0) ||
                      (cfg_s_height == '0) || (cfg_m_height == '0);
    assign start_ok = (state_reg == S_IDLE) && start && !cfg_bad;

    always_comb begin
        state_next    = state_reg;
        h_core_resetn = 1'b0;
        v_core_resetn = 1'b0;
        h_enable      = 1'b0;
        v_enable      = 1'b0;
        s_line_pop    = 1'b0;
        m_line_done   = 1'b0;
        frame_done    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_ok)
                    state_next = S_CLR;
            end
            S_CLR: begin
                if (clr_cnt_reg)
                    state_next = S_VSTEP;
            end
            S_VSTEP: begin
                h_core_resetn = 1'b1;
                v_core_resetn = 1'b1;
                v_enable      = 1'b1;
                state_next    = S_VEVAL;
            end
            S_VEVAL: begin
                h_core_resetn = 1'b1;
                v_core_resetn = 1'b1;
                if (v_d_valid) begin
                    state_next = S_HWAIT;
                end else begin
                    // Source-only step: the line is consumed without producing output.
                    s_line_pop = 1'b1;
                    state_next = v_a_last ? S_DONE : S_VSTEP;
                end
            end
            S_HWAIT: begin
                h_core_resetn = 1'b1;
                v_core_resetn = 1'b1;
                if (s_line_avail)
                    state_next = S_HRUN;
            end
            S_HRUN: begin
                h_core_resetn = 1'b1;
                v_core_resetn = 1'b1;
                h_enable      = m_line_ready;
                if (m_line_ready && h_a_last)
                    state_next = S_LEND;
            end
            S_LEND: begin
                v_core_resetn = 1'b1;
                m_line_done   = 1'b1;
                s_line_pop    = s_adv_reg;
                state_next    = a_last_reg ? S_DONE : S_VSTEP;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort overrides any transition, including the end of a line in HRUN.
        if (state_reg != S_IDLE && abort) begin
            state_next = S_IDLE;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            clr_cnt_reg  <= 1'b0;
            s_adv_reg    <= 1'b0;
            a_last_reg   <= 1'b0;
            cfg_err_reg  <= 1'b0;
            out_line_reg <= '0;
            h_s_nbr_reg  <= '0;
            h_m_nbr_reg  <= '0;
            v_s_nbr_reg  <= '0;
            v_m_nbr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= (state_reg == S_IDLE) && start && cfg_bad;
            clr_cnt_reg <= (state_reg == S_CLR) ? ~clr_cnt_reg : 1'b0;
            if (start_ok) begin
                h_s_nbr_reg <= cfg_s_width;
                h_m_nbr_reg <= cfg_m_width;
                v_s_nbr_reg <= cfg_s_height;
                v_m_nbr_reg <= cfg_m_height;
            end
            if (state_reg == S_VEVAL) begin
                s_adv_reg  <= v_s_advance;
                a_last_reg <= v_a_last;
            end
            if (state_reg == S_CLR)
                out_line_reg <= '0;
            else if (state_reg == S_LEND && out_line_reg < v_m_nbr_reg - H_ONE)
                out_line_reg <= out_line_reg + H_ONE;
        end
    end

    assign h_s_nbr  = h_s_nbr_reg;
    assign h_m_nbr  = h_m_nbr_reg;
    assign v_s_nbr  = v_s_nbr_reg;
    assign v_m_nbr  = v_m_nbr_reg;
    assign out_line = out_line_reg;
    assign busy     = (state_reg != S_IDLE);
    assign cfg_err  = cfg_err_reg;

endmodule
